// File: rtl/freq_generator_if.sv
// ---------------------------------------------------------------------------
// freq_generator_if
//
// Request/status bundle of the programmable square-wave generator.
//
//   freq_in      requested frequency in Hz (sampled only when a load is taken)
//   freq_load    one-cycle load strobe
//   busy         divider running; loads are ignored while high
//   freq_active  frequency currently being generated, 0 when stopped
//   wave_out     generated 50 % duty square wave (registered)
//
// Modports:
//   master  the requester (drives freq_in / freq_load, observes status)
//   slave   the generator itself
// ---------------------------------------------------------------------------
interface freq_generator_if #(
  parameter int FREQ_W = 17
);

  logic [FREQ_W-1:0] freq_in;
  logic              freq_load;
  logic              busy;
  logic [FREQ_W-1:0] freq_active;
  logic              wave_out;

  modport master (
    output freq_in,
    output freq_load,
    input  busy,
    input  freq_active,
    input  wave_out
  );

  modport slave (
    input  freq_in,
    input  freq_load,
    output busy,
    output freq_active,
    output wave_out
  );

endinterface : freq_generator_if

// File: rtl/freq_generator.sv
// ---------------------------------------------------------------------------
// freq_generator
//
// Programmable square-wave generator. A requested frequency (Hz) is turned
// into a half-period in system-clock cycles by a 32-step restoring divider:
//
//   half_period = max(1, floor(CLK_HZ / (2 * freq_in)))
//
// and a half-period counter then toggles wave_out every half_period cycles,
// giving a 50 % duty output of period 2 * half_period cycles.
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz (the dividend, 32 bits)
//   FREQ_W  width of the frequency request
//
// Ports:
//   MAX10_CLK1_50  system clock, all logic on its rising edge
//   SW0            synchronous active-low reset
//   bus            freq_generator_if.slave (freq_in, freq_load, busy,
//                  freq_active, wave_out)
//   tick           one-cycle pulse on every 0->1 transition of wave_out
//                  (only when FREQGEN_TICK_EN is defined)
//
// Optional feature:
//   FREQGEN_TICK_EN  when defined, adds the tick output and its register.
//                    When undefined, neither the port nor the logic exists.
//
// Behaviour summary:
//   IDLE  stopped, wave_out = 0, freq_active = 0.
//   DIV   exactly 32 cycles, one quotient bit per cycle, MSB first. If the
//         generator was already running, the old waveform keeps going
//         during the divide.
//   RUN   generating. On entry the counter is cleared but wave_out keeps
//         its level, so a frequency change never glitches the output.
//   A load of 0 stops the generator on the next cycle without dividing.
//   Loads arriving while busy are dropped.
// ---------------------------------------------------------------------------
module freq_generator #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          FREQ_W = 17
) (
  input  logic             MAX10_CLK1_50,
  input  logic             SW0,
  freq_generator_if.slave  bus
`ifdef FREQGEN_TICK_EN
  ,
  output logic             tick
`endif
);

  // Divisor is 2 * freq_in, so it needs one bit more than the request.
  localparam int          DW       = FREQ_W + 1;
  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e            state_q,    state_d;
  logic [4:0]        bit_cnt_q,  bit_cnt_d;    // divide step, 0..31
  logic [DW-1:0]     divisor_q,  divisor_d;    // latched 2 * freq_in
  logic [DW-1:0]     rem_q,      rem_d;        // partial remainder
  logic [30:0]       quo_q,      quo_d;        // quotient bits so far
  logic [FREQ_W-1:0] freq_lat_q, freq_lat_d;   // request being divided
  logic [31:0]       half_q,     half_d;       // half-period in cycles
  logic [31:0]       cnt_q,      cnt_d;        // half-period counter
  logic              wave_q,     wave_d;
  logic [FREQ_W-1:0] active_q,   active_d;

  // -------------------------------------------------------------------------
  // Divider datapath (one restoring step per cycle)
  // -------------------------------------------------------------------------
  logic [DW:0]   rem_shift;
  logic [DW-1:0] rem_sub;
  logic          fits;
  logic [31:0]   quo_next;

  always_comb begin
    // Bring down the next dividend bit, MSB first: bit index 31 - step,
    // which for a 5-bit step is simply its complement.
    rem_shift = {rem_q, DIVIDEND[~bit_cnt_q]};
    fits      = (rem_shift >= {1'b0, divisor_q});
    // When the divisor fits, the difference is below the divisor, so the
    // low DW bits hold it exactly.
    rem_sub   = rem_shift[DW-1:0] - divisor_q;
    quo_next  = {quo_q, fits};
  end

  // -------------------------------------------------------------------------
  // Waveform counter helpers
  // -------------------------------------------------------------------------
  logic running;
  logic half_hit;

  always_comb begin
    // A non-zero active frequency means a valid half-period is loaded; this
    // keeps the old waveform alive while a new divide is in progress.
    running  = (active_q != '0);
    half_hit = (cnt_q == half_q - 32'd1);
  end

  logic load_ok;
  assign load_ok = bus.freq_load && (state_q != ST_DIV);

  // -------------------------------------------------------------------------
  // Next-state / datapath control
  // -------------------------------------------------------------------------
  // NOTE: every variable written below gets a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    freq_lat_d = freq_lat_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    wave_d     = wave_q;
    active_d   = active_q;

    // Free-running half-period counter, overridden below by load/completion.
    if (running) begin
      if (half_hit) begin
        cnt_d  = 32'd0;
        wave_d = ~wave_q;
      end else begin
        cnt_d  = cnt_q + 32'd1;
      end
    end

    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_ok) begin
          if (bus.freq_in == '0) begin
            // Stop request: no divide, output forced low immediately.
            state_d  = ST_IDLE;
            wave_d   = 1'b0;
            active_d = '0;
            cnt_d    = 32'd0;
          end else begin
            state_d    = ST_DIV;
            divisor_d  = {bus.freq_in, 1'b0};
            rem_d      = '0;
            quo_d      = '0;
            bit_cnt_d  = 5'd0;
            freq_lat_d = bus.freq_in;
          end
        end
      end

      ST_DIV: begin
        rem_d     = fits ? rem_sub : rem_shift[DW-1:0];
        quo_d     = quo_next[30:0];
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          state_d  = ST_RUN;
          // Requests above CLK_HZ/2 give a zero quotient; clamp to 1 so the
          // counter never compares against -1.
          half_d   = (quo_next == 32'd0) ? 32'd1 : quo_next;
          active_d = freq_lat_q;
          cnt_d    = 32'd0;
          // Keep the current level at the switchover: no glitch, no
          // forced phase.
          wave_d   = wave_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  // NOTE: every register, including the divider working set and the
  // half-period, is cleared by reset; none of them is a memory array.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!SW0) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      freq_lat_q <= '0;
      half_q     <= '0;
      cnt_q      <= '0;
      wave_q     <= 1'b0;
      active_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      freq_lat_q <= freq_lat_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      wave_q     <= wave_d;
      active_q   <= active_d;
    end
  end

`ifdef FREQGEN_TICK_EN
  // Registered alongside wave_out: high exactly in the cycle wave_out
  // becomes 1. IDLE and the switchover hold or clear the level, so no
  // spurious pulse can appear there.
  logic tick_q, tick_d;

  always_comb begin
    tick_d = wave_d & ~wave_q;
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!SW0) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.busy        = (state_q == ST_DIV);
  assign bus.freq_active = active_q;
  assign bus.wave_out    = wave_q;

endmodule : freq_generator

// File: tb/tb_freq_generator.sv
// ---------------------------------------------------------------------------
// tb_freq_generator
//
// Self-checking bench for freq_generator. A reduced CLK_HZ keeps the run
// short while still reaching the clamp (quotient 0 -> half_period 1).
// A cycle-by-cycle reference model predicts wave_out, busy, freq_active (and
// tick) from the load history using plain arithmetic on edge numbers.
// ---------------------------------------------------------------------------
module tb_freq_generator;

  localparam int unsigned CLK_HZ = 200_000;
  localparam int          FREQ_W = 17;

  logic clk = 1'b0;
  logic sw0 = 1'b0;

  always #5 clk = ~clk;

  freq_generator_if #(.FREQ_W(FREQ_W)) bus ();

`ifdef FREQGEN_TICK_EN
  logic tick;
`endif

  freq_generator #(
    .CLK_HZ (CLK_HZ),
    .FREQ_W (FREQ_W)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .SW0           (sw0),
    .bus           (bus)
`ifdef FREQGEN_TICK_EN
    ,
    .tick          (tick)
`endif
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic longint exp_half(input int f);
    longint q;
    q = longint'(CLK_HZ) / (2 * longint'(f));
    return (q == 0) ? 64'd1 : q;
  endfunction

  int unsigned cyc = 0;       // number of rising edges seen
  logic        ld_s, rst_s;
  logic [FREQ_W-1:0] fin_s;

  bit          m_run = 1'b0;  // valid waveform in progress
  bit          m_pend = 1'b0; // divide in progress
  bit          m_ref_level = 1'b0;
  int unsigned m_ref_edge = 0;
  int unsigned m_pend_edge = 0;
  longint      m_hp = 1, m_pend_hp = 1;
  int          m_freq = 0, m_pend_freq = 0;

  // Level after edge e: counter restarts at m_ref_edge, one toggle every m_hp.
  function automatic bit wave_at(input int unsigned e);
    if (!m_run) return 1'b0;
    return m_ref_level ^ bit'((longint'(e - m_ref_edge) / m_hp) % 2);
  endfunction

  function automatic bit tick_at(input int unsigned e);
    if (!m_run || e <= m_ref_edge) return 1'b0;
    return ((longint'(e - m_ref_edge) % m_hp) == 0) && wave_at(e);
  endfunction

  bit          mon_en = 1'b0;
  int          stream_err = 0;
  int unsigned stream_first = 0;

  // Capture the stimulus present at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc   = cyc + 1;
      ld_s  = bus.freq_load;
      fin_s = bus.freq_in;
      rst_s = sw0;
    end
  end

  // Advance the model for the edge just taken, then compare.
  initial begin
    bit                lvl;
    bit                e_wave, e_busy;
    logic [FREQ_W-1:0] e_freq;
    bit                bad;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!rst_s) begin
          m_run  = 1'b0;
          m_pend = 1'b0;
        end else if (m_pend && cyc == m_pend_edge) begin
          lvl         = wave_at(cyc - 1);
          m_ref_level = lvl;
          m_ref_edge  = cyc;
          m_hp        = m_pend_hp;
          m_freq      = m_pend_freq;
          m_run       = 1'b1;
          m_pend      = 1'b0;
        end else if (ld_s && !m_pend) begin
          if (fin_s == '0) begin
            m_run = 1'b0;
          end else begin
            m_pend      = 1'b1;
            m_pend_edge = cyc + 32;
            m_pend_hp   = exp_half(int'(fin_s));
            m_pend_freq = int'(fin_s);
          end
        end
        e_wave = wave_at(cyc);
        e_busy = m_pend;
        e_freq = m_run ? FREQ_W'(m_freq) : '0;
        bad = (bus.wave_out !== e_wave) || (bus.busy !== e_busy) ||
              (bus.freq_active !== e_freq);
`ifdef FREQGEN_TICK_EN
        bad = bad || (tick !== tick_at(cyc));
`endif
        if (bad) begin
          if (stream_err == 0) stream_first = cyc;
          stream_err++;
        end
      end
    end
  end

  task automatic check_stream(input string name);
    check(name, 64'(stream_err), 64'd0);
    if (stream_err != 0)
      $display("  %s: first divergence from model at edge %0d", name, stream_first);
    stream_err = 0;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  // Returns at the falling edge right after the acceptance edge.
  task automatic load(input int f);
    @(negedge clk);
    bus.freq_in   = FREQ_W'(f);
    bus.freq_load = 1'b1;
    @(negedge clk);
    bus.freq_load = 1'b0;
  endtask

  // Counts busy cycles (bounded); optionally pulses a load mid-divide.
  task automatic wait_done(input int pulse_at, input int pulse_freq,
                           output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (n == pulse_at) begin
        bus.freq_in   = FREQ_W'(pulse_freq);
        bus.freq_load = 1'b1;
      end else begin
        bus.freq_load = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.freq_load = 1'b0;
  endtask

  // Cycles until wave_out changes level; -1 if the bound expires.
  task automatic measure_toggle(input int limit, output int n);
    logic l0;
    int   k;
    l0 = bus.wave_out;
    n  = -1;
    k  = 0;
    while (k < limit) begin
      @(negedge clk);
      k++;
      if (bus.wave_out !== l0) begin
        n = k;
        break;
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Test
  // -------------------------------------------------------------------------
  typedef struct {
    int freq;
    int exp_hp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n, t;
    tbl[0] = '{1000,   100};
    tbl[1] = '{2000,    50};
    tbl[2] = '{131071,   1};   // quotient 0 -> clamp
    tbl[3] = '{60000,    1};
    tbl[4] = '{40000,    2};
    tbl[5] = '{333,    300};
    tbl[6] = '{500,    200};
    tbl[7] = '{49,    2040};

    bus.freq_in   = '0;
    bus.freq_load = 1'b0;
    sw0           = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_wave",   64'(bus.wave_out),    64'd0);
    check("reset_busy",   64'(bus.busy),        64'd0);
    check("reset_active", 64'(bus.freq_active), 64'd0);
`ifdef FREQGEN_TICK_EN
    check("reset_tick",   64'(tick),            64'd0);
`endif
    sw0    = 1'b1;
    mon_en = 1'b1;

    // Basic load from IDLE.
    load(1000);
    check("load_busy_now", 64'(bus.busy), 64'd1);
    wait_done(-1, 0, n);
    check("load_busy_len", 64'(n), 64'd32);
    check("load_active",   64'(bus.freq_active), 64'd1000);
    check("load_wave_lvl", 64'(bus.wave_out), 64'd0);
    measure_toggle(1000, t);  check("load_first",  64'(t), 64'd100);
    measure_toggle(1000, t);  check("load_high",   64'(t), 64'd100);
    measure_toggle(1000, t);  check("load_low",    64'(t), 64'd100);

`ifdef FREQGEN_TICK_EN
    begin
      int ticks, rises, odd;
      logic prev;
      ticks = 0; rises = 0; odd = 0;
      prev  = bus.wave_out;
      repeat (1000) begin
        @(negedge clk);
        if (tick === 1'b1) ticks++;
        if (bus.wave_out === 1'b1 && prev === 1'b0) rises++;
        if (tick !== (bus.wave_out & ~prev)) odd++;
        prev = bus.wave_out;
      end
      check("tick_count",    64'(ticks), 64'd5);
      check("tick_coincide", 64'(odd),   64'd0);
      check("tick_rises",    64'(rises), 64'(ticks));
    end
`endif

    // Frequency change while running, with a dropped load mid-divide.
    repeat (37) @(negedge clk);
    load(2000);
    wait_done(10, 40000, n);
    check("switch_busy_len", 64'(n), 64'd32);
    check("switch_active",   64'(bus.freq_active), 64'd2000);
    measure_toggle(1000, t); check("switch_first", 64'(t), 64'd50);
    measure_toggle(1000, t); check("switch_next",  64'(t), 64'd50);
    check_stream("stream_basic");

    // Stop with a zero load.
    repeat (13) @(negedge clk);
    load(0);
    check("stop_wave",   64'(bus.wave_out),    64'd0);
    check("stop_active", 64'(bus.freq_active), 64'd0);
    check("stop_busy",   64'(bus.busy),        64'd0);
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.wave_out !== 1'b0 || bus.busy !== 1'b0 || bus.freq_active !== '0) n++;
    end
    check("stop_hold", 64'(n), 64'd0);

    // Table of divide results, measured on the waveform.
    for (int i = 0; i < 8; i++) begin
      load(tbl[i].freq);
      wait_done(-1, 0, n);
      check($sformatf("tbl%0d_busy", i),   64'(n), 64'd32);
      check($sformatf("tbl%0d_active", i), 64'(bus.freq_active), 64'(tbl[i].freq));
      measure_toggle(5000, t);
      check($sformatf("tbl%0d_first", i),  64'(t), 64'(tbl[i].exp_hp));
      measure_toggle(5000, t);
      check($sformatf("tbl%0d_second", i), 64'(t), 64'(tbl[i].exp_hp));
    end
    check_stream("stream_table");

    // Reset in the middle of a divide.
    load(1000);
    repeat (10) @(negedge clk);
    check("rst_div_busy", 64'(bus.busy), 64'd1);
    sw0 = 1'b0;
    @(negedge clk);
    check("rst_div_wave",   64'(bus.wave_out),    64'd0);
    check("rst_div_busyq",  64'(bus.busy),        64'd0);
    check("rst_div_active", 64'(bus.freq_active), 64'd0);
`ifdef FREQGEN_TICK_EN
    check("rst_div_tick",   64'(tick),            64'd0);
`endif
    sw0 = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_idle_busy", 64'(bus.busy), 64'd0);
    load(500);
    wait_done(-1, 0, n);
    check("rst_reload_busy", 64'(n), 64'd32);
    measure_toggle(1000, t);
    check("rst_reload_first", 64'(t), 64'd200);
    check_stream("stream_reset");

    // Randomised loads, stops and dropped loads against the model.
    for (int i = 0; i < 25; i++) begin
      int r, f;
      r = $urandom_range(0, 9);
      if (r == 0)      f = 0;
      else if (r == 1) f = $urandom_range(40000, 131071);
      else             f = $urandom_range(20, 2000);
      load(f);
      if (f != 0) begin
        wait_done($urandom_range(0, 40), $urandom_range(0, 131071), n);
        check("rnd_busy_len", 64'(n), 64'd32);
        check("rnd_active",   64'(bus.freq_active), 64'(f));
      end
      repeat ($urandom_range(1, 400)) @(negedge clk);
    end
    check_stream("stream_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation did not finish");
  end

endmodule : tb_freq_generator
